lockin_demod: RTL

Synchronous (lock-in) demodulator for the atomic-clock servo loop. It takes signed photodetector ADC samples and multiplies them by a ±1 square reference, derived from the modulation DDS phase plus a programmable demodulation phase offset. Results are integrated over a programmable number of modulation periods, and one saturated error word is emitted per window for the frequency-correction loop. It is the receive-side counterpart of the DDS modulation generator and runs on the same clock as that generator.

---
 rtl/lockin_demod_if.sv | 21 ++
 rtl/lockin_demod.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lockin_demod_if.sv
// Sample stream into the lock-in demodulator and the per-window result
// stream back out to the frequency-correction loop.
interface lockin_demod_if #(
  parameter int ADC_WIDTH = 16
);
  logic signed [ADC_WIDTH-1:0] adc_data;
  logic                        adc_valid;
  logic signed [31:0]          demod_err;
  logic [15:0]                 demod_cnt;
  logic                        demod_valid;

  modport master (
    output adc_data, adc_valid,
    input  demod_err, demod_cnt, demod_valid
  );

  modport slave (
    input  adc_data, adc_valid,
    output demod_err, demod_cnt, demod_valid
  );
endinterface

// File: rtl/lockin_demod.sv
// Lock-in demodulator: multiplies ADC samples by a +/-1 square reference
// derived from the DDS phase plus an offset, integrates over N modulation
// periods and emits one saturated error word per window (gapless windows).
module lockin_demod #(
  parameter int ADC_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int PH_WIDTH  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                demod_en,
  input  logic [PH_WIDTH-1:0] mod_phase,
  input  logic [PH_WIDTH-1:0] DEMOD_PCW_VIO,
  input  logic [7:0]          DEMOD_NUM_VIO,
  input  logic [7:0]          DEMOD_SKIP_VIO,
  output logic                demod_busy,
  lockin_demod_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PH_WIDTH-1:0]         ref_phase;
  logic                        sgn;
  logic                        prev_sign;
  logic                        transition;
  logic                        boundary;

  logic [7:0]                  skip_q, skip_d;
  logic                        take;

  logic signed [ADC_WIDTH-1:0] adc_s;
  logic signed [ACC_WIDTH-1:0] sext;
  logic signed [ACC_WIDTH-1:0] contrib;
  logic signed [ACC_WIDTH-1:0] add_val;
  logic signed [ACC_WIDTH-1:0] acc_q;

  logic [7:0]                  period_q;
  logic [7:0]                  n_lat_q;
  logic [7:0]                  num_eff;
  logic [15:0]                 sample_q;
  logic [15:0]                 sample_inc;
  logic                        close_win;
  logic signed [31:0]          sat_err;

  assign adc_s      = bus.adc_data;
  assign demod_busy = (state_q != IDLE);

  // Reference sign, transition and period-boundary detection.
  always_comb begin
    ref_phase  = mod_phase + DEMOD_PCW_VIO;
    sgn        = ref_phase[PH_WIDTH-1];
    transition = sgn ^ prev_sign;
    boundary   = prev_sign & ~sgn;
    num_eff    = (DEMOD_NUM_VIO == 8'd0) ? 8'd1 : DEMOD_NUM_VIO;
  end

  // Signed contribution of the current sample; -2^(ADC_WIDTH-1) negates
  // exactly because the negation happens at accumulator width.
  always_comb begin
    sext    = {{(ACC_WIDTH-ADC_WIDTH){adc_s[ADC_WIDTH-1]}}, adc_s};
    contrib = sgn ? -sext : sext;
    add_val = take ? contrib : '0;
  end

  // Post-transition skip counter; a sample arriving on the transition
  // cycle itself is the first skipped sample under the new sign.
  always_comb begin
    skip_d = skip_q;
    take   = 1'b0;
    if (transition) begin
      skip_d = DEMOD_SKIP_VIO;
      if (bus.adc_valid) begin
        if (DEMOD_SKIP_VIO == 8'd0) take = 1'b1;
        else                        skip_d = DEMOD_SKIP_VIO - 8'd1;
      end
    end else if (bus.adc_valid) begin
      if (skip_q != 8'd0) skip_d = skip_q - 8'd1;
      else                take   = 1'b1;
    end
  end

  // Saturating sample count and 32-bit clipping of the accumulator.
  always_comb begin
    sample_inc = (take && (sample_q != '1)) ? sample_q + 16'd1 : sample_q;
    sat_err    = acc_q[31:0];
    if (acc_q[ACC_WIDTH-1:31] != {(ACC_WIDTH-31){acc_q[ACC_WIDTH-1]}})
      sat_err = acc_q[ACC_WIDTH-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
  end

  // Next-state logic and window-close decode.
  always_comb begin
    state_d   = state_q;
    close_win = 1'b0;
    case (state_q)
      IDLE: begin
        if (demod_en) state_d = SYNC;
      end
      SYNC: begin
        if (!demod_en)     state_d = IDLE;
        else if (boundary) state_d = ACCUM;
      end
      ACCUM: begin
        if (!demod_en) state_d = IDLE;
        else           close_win = boundary && (period_q == n_lat_q - 8'd1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Previous reference sign tracks the reference in every state so that
  // enabling never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_sign <= 1'b0;
    else        prev_sign <= sgn;
  end

  // Accumulation datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q           <= '0;
      period_q        <= '0;
      skip_q          <= '0;
      sample_q        <= '0;
      n_lat_q         <= '0;
      bus.demod_err   <= '0;
      bus.demod_cnt   <= '0;
      bus.demod_valid <= 1'b0;
    end else begin
      bus.demod_valid <= 1'b0;
      if (state_q == IDLE || !demod_en) begin
        acc_q    <= '0;
        period_q <= '0;
        skip_q   <= '0;
        sample_q <= '0;
      end else begin
        skip_q <= skip_d;
        if (state_q == SYNC) begin
          if (boundary) begin
            acc_q    <= add_val;
            sample_q <= {15'd0, take};
            period_q <= '0;
            n_lat_q  <= num_eff;
          end
        end else if (close_win) begin
          // The closing boundary's own sample opens the next window.
          bus.demod_err   <= sat_err;
          bus.demod_cnt   <= sample_q;
          bus.demod_valid <= 1'b1;
          acc_q           <= add_val;
          sample_q        <= {15'd0, take};
          period_q        <= '0;
          n_lat_q         <= num_eff;
        end else begin
          acc_q    <= acc_q + add_val;
          sample_q <= sample_inc;
          if (boundary) period_q <= period_q + 8'd1;
        end
      end
    end
  end

endmodule
